alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// Alarm controller: arms on alarm_en, rings on a rising time/alarm match,
// supports a bounded number of snoozes and auto-stops after RING_SECS.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CW          = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  input  logic [3:0] timeminsunits,
  input  logic [3:0] timeminstens,
  input  logic [3:0] timehrsunits,
  input  logic [3:0] timehrstens,
  input  logic [3:0] alarmminsunits,
  input  logic [3:0] alarmminstens,
  input  logic [3:0] alarmhrsunits,
  input  logic [3:0] alarmhrstens,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzz,
  output logic [1:0] snooze_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZE);

  state_t        state, state_nxt;
  logic          match, match_q, stop_q, snooze_q;
  logic          match_rise, stop_rise, snooze_rise;
  logic [CW-1:0] sec_cnt, sec_cnt_nxt;
  logic [1:0]    snooze_cnt_nxt;
  logic          buzz_nxt;

  assign match = (timeminsunits == alarmminsunits) && (timeminstens == alarmminstens) &&
                 (timehrsunits == alarmhrsunits) && (timehrstens == alarmhrstens);

  assign match_rise  = match & ~match_q;
  assign stop_rise   = stop & ~stop_q;
  assign snooze_rise = snooze & ~snooze_q;
  assign state_dbg   = state;

  always_comb begin
    state_nxt      = state;
    sec_cnt_nxt    = sec_cnt;
    snooze_cnt_nxt = snooze_cnt;
    buzz_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (alarm_en) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (match_rise) begin
          state_nxt   = S_RINGING;
          sec_cnt_nxt = '0;
          buzz_nxt    = 1'b1;
        end
      end
      S_RINGING: begin
        buzz_nxt = buzz;
        // Stop beats snooze; a snooze beyond the allowance acts as stop.
        if (stop_rise) begin
          state_nxt = S_ARMED;
        end else if (snooze_rise) begin
          if (snooze_cnt < MAX_CNT) begin
            state_nxt      = S_SNOOZE;
            sec_cnt_nxt    = '0;
            snooze_cnt_nxt = snooze_cnt + 2'd1;
          end else begin
            state_nxt = S_ARMED;
          end
        end else if (tick) begin
          if (sec_cnt == RING_LAST) begin
            state_nxt = S_ARMED;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
            buzz_nxt    = ~buzz;
          end
        end
      end
      S_SNOOZE: begin
        if (stop_rise) begin
          state_nxt = S_ARMED;
        end else if (tick) begin
          if (sec_cnt == SNOOZE_LAST) begin
            state_nxt   = S_RINGING;
            sec_cnt_nxt = '0;
            buzz_nxt    = 1'b1;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (!alarm_en) state_nxt = S_IDLE;

    // Leaving the alarm event: forget snoozes and silence the buzzer.
    if (state_nxt == S_IDLE || state_nxt == S_ARMED) begin
      snooze_cnt_nxt = '0;
      sec_cnt_nxt    = '0;
    end
    if (state_nxt != S_RINGING) buzz_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b0;
      stop_q     <= 1'b0;
      snooze_q   <= 1'b0;
      armed      <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      buzz       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sec_cnt    <= sec_cnt_nxt;
      snooze_cnt <= snooze_cnt_nxt;
      match_q    <= match;
      stop_q     <= stop;
      snooze_q   <= snooze;
      armed      <= (state_nxt != S_IDLE);
      ringing    <= (state_nxt == S_RINGING);
      snoozing   <= (state_nxt == S_SNOOZE);
      buzz       <= buzz_nxt;
    end
  end

endmodule
